rx_deframer: RTL

Downstream consumer of the ring buffer's serial output. Samples rxda on each outstrobe qualifier and hunts for a sync word. Once locked, it assembles fixed-width parity-protected words and delivers them through a small show-ahead output FIFO with a valid/ready handshake. It reports lock status, parity errors and FIFO overflow to the host side.

---
 rtl/rx_deframer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/rx_deframer.sv
// Serial deframer: hunts for a sync word, then unpacks even-parity frames
// into a small show-ahead FIFO with a valid/ready output handshake.
module rx_deframer #(
    parameter int                    data_width = 8,
    parameter logic [data_width-1:0] sync_word  = 8'hA5,
    parameter int                    fifo_depth = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rxda,
    input  logic                  outstrobe,
    output logic [data_width-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  locked,
    output logic                  parity_err,
    output logic                  overflow
);

    localparam int AW = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
    localparam int CW = AW + 1;
    localparam int BW = $clog2(data_width + 1);

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(fifo_depth);
    localparam logic [BW-1:0] BIT_LAST = BW'(data_width - 1);

    typedef enum logic [1:0] {
        HUNT,
        DATA,
        PARITY
    } state_t;

    state_t                state;
    logic [data_width-1:0] shift_reg;
    logic [BW-1:0]         bit_cnt;
    logic [1:0]            err_cnt;

    logic [data_width-1:0] mem [fifo_depth];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;

    logic [data_width-1:0] shifted;
    logic                  parity_ok;
    logic                  frame_good;
    logic                  frame_bad;
    logic                  pop;
    logic                  full;
    logic                  push;
    logic [AW-1:0]         rd_next;
    logic [CW-1:0]         count_next;
    logic [data_width-1:0] head_next;

    always_comb begin
        shifted    = {shift_reg[data_width-2:0], rxda};
        parity_ok  = ~(^shift_reg ^ rxda);
        frame_good = outstrobe && (state == PARITY) && parity_ok;
        frame_bad  = outstrobe && (state == PARITY) && !parity_ok;
        pop        = dout_valid && dout_ready;
        full       = (count == CNT_FULL);
        push       = frame_good && (!full || pop);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= HUNT;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            err_cnt    <= '0;
            locked     <= 1'b0;
            parity_err <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            parity_err <= frame_bad;
            overflow   <= frame_good && full && !pop;
            if (outstrobe) begin
                shift_reg <= shifted;
                case (state)
                    HUNT: begin
                        if (shifted == sync_word) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                            err_cnt <= '0;
                            locked  <= 1'b1;
                        end
                    end
                    DATA: begin
                        if (bit_cnt == BIT_LAST) begin
                            state   <= PARITY;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                    PARITY: begin
                        if (parity_ok) begin
                            err_cnt <= '0;
                            state   <= DATA;
                        end else if (err_cnt != 2'd0) begin
                            // Second consecutive bad frame: drop lock and rehunt from a clean register
                            err_cnt   <= err_cnt + 2'd1;
                            state     <= HUNT;
                            shift_reg <= '0;
                            locked    <= 1'b0;
                        end else begin
                            err_cnt <= err_cnt + 2'd1;
                            state   <= DATA;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

    // When the pushed word becomes the only entry it must bypass the array into dout
    always_comb begin
        rd_next = pop ? rd_ptr + PTR_ONE : rd_ptr;
        case ({push, pop})
            2'b10:   count_next = count + CNT_ONE;
            2'b01:   count_next = count - CNT_ONE;
            default: count_next = count;
        endcase
        head_next = (push && count_next == CNT_ONE) ? shift_reg : mem[rd_next];
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= shift_reg;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            rd_ptr     <= rd_next;
            count      <= count_next;
            dout_valid <= (count_next != '0);
            if (count_next != '0) begin
                dout <= head_next;
            end
        end
    end

endmodule
